// File: rtl/demux1pn_reg.sv
// -----------------------------------------------------------------------------
// demux1pn_reg
//
// Registered 1-to-N stream demultiplexer with valid/ready handshake.
// A single producer offers one word per cycle together with a destination
// index (sel) or a broadcast flag (bcast). The word is loaded into the
// one-entry output register of the chosen channel, or into every channel
// when broadcasting. All outputs except in_ready come straight from
// registers, so the block breaks timing paths between producer and consumers.
//
// A word whose sel does not name an existing channel is still accepted, but
// it is discarded. It raises a one-cycle err pulse and bumps a saturating
// drop counter.
//
// Parameters
//   DATA_W  width of a data word
//   N_OUT   number of output channels, 2 .. 2**SEL_W
//   SEL_W   width of the channel index
//   CNT_W   width of the saturating drop counter
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low
//   data_in    in   input word
//   sel        in   destination channel index
//   bcast      in   1 = deliver the word to every channel
//   in_valid   in   data_in/sel/bcast are valid
//   in_ready   out  block accepts this cycle (combinational from sel, bcast,
//                   out_ready and the channel state; never from in_valid)
//   out        out  channel i data = out[i*DATA_W +: DATA_W]
//   out_valid  out  channel i holds a word
//   out_ready  in   consumer i takes its word this cycle
//   err        out  one-cycle pulse per dropped (out-of-range sel) word
//   drop_cnt   out  number of dropped words, saturating at all-ones
// -----------------------------------------------------------------------------
module demux1pn_reg #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    bcast,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    err,
  output logic [CNT_W-1:0]        drop_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N_OUT-1:0][DATA_W-1:0] data_q,  data_d;
  logic [N_OUT-1:0]             valid_q, valid_d;
  logic                         err_q,   err_d;
  logic [CNT_W-1:0]             cnt_q,   cnt_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [N_OUT-1:0] chan_free;  // channel can take a word this cycle
  logic [N_OUT-1:0] sel_hit;    // one-hot decode of sel over real channels
  logic             sel_ok;     // sel names an existing channel
  logic             accept;
  logic [N_OUT-1:0] load;       // per-channel load strobe
  logic             drop;       // accepted word with an out-of-range sel

  // A full channel is still free if its consumer drains it in the same
  // cycle, which gives one word per cycle per channel under steady ready.
  assign chan_free = ~valid_q | out_ready;

  // NOTE: every signal written in an always_comb gets a default value at
  // the top of the block, so no path through it can infer a latch.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sel_hit[i] = (sel == SEL_W'(i));
    end
  end

  // When sel is out of range, sel_hit is all zero.
  assign sel_ok = |sel_hit;

  // Broadcast is all-or-none. It waits until every channel is free, so a
  // stalled consumer never causes a partial delivery. A bad sel is always
  // ready, because that word is consumed and discarded.
  always_comb begin
    in_ready = 1'b1;
    if (bcast) begin
      in_ready = &chan_free;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & chan_free);
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load = bcast ? {N_OUT{1'b1}} : sel_hit;
    end
  end

  assign drop = accept & ~bcast & ~sel_ok;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Per channel:
  //   load             -> take the new word, stay / become valid
  //   ready, no load   -> word consumed, valid clears, data keeps last value
  //   otherwise        -> hold (stalled words are never overwritten)
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (load[i]) begin
        data_d[i]  = data_in;
        valid_d[i] = 1'b1;
      end else if (out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    err_d = drop;
    cnt_d = cnt_q;
    if (drop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the data registers are reset as well as the valid bits. Outputs
  // must read back as zero during reset, and N_OUT words are cheap to clear.
  // NOTE: sequential state is updated only with non-blocking assignments.
  // Every register then samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Packed layout places channel i at bits [i*DATA_W +: DATA_W].
  assign out       = data_q;
  assign out_valid = valid_q;
  assign err       = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux1pn_reg.sv
// -----------------------------------------------------------------------------
// tb_demux1pn_reg
//
// Bench for demux1pn_reg. Two instances share the same producer-side
// stimulus:
//   dut4 : default parameters (4 channels, 8-bit drop counter)
//   dut3 : N_OUT=3, CNT_W=2, so sel=3 is out of range and the counter
//          saturates at 3
// A behavioural reference model keeps, per instance, the word held by each
// channel and the drop count. It predicts in_ready and all outputs.
// -----------------------------------------------------------------------------
module tb_demux1pn_reg;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic [1:0]  sel;
  logic        bcast;
  logic        in_valid;
  logic [3:0]  out_ready;

  logic        rdy4, err4;
  logic [31:0] out4;
  logic [3:0]  ov4;
  logic [7:0]  cnt4;

  logic        rdy3, err3;
  logic [23:0] out3;
  logic [2:0]  ov3;
  logic [1:0]  cnt3;

  demux1pn_reg #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .sel       (sel),
    .bcast     (bcast),
    .in_valid  (in_valid),
    .in_ready  (rdy4),
    .out       (out4),
    .out_valid (ov4),
    .out_ready (out_ready),
    .err       (err4),
    .drop_cnt  (cnt4)
  );

  demux1pn_reg #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .sel       (sel),
    .bcast     (bcast),
    .in_valid  (in_valid),
    .in_ready  (rdy3),
    .out       (out3),
    .out_valid (ov3),
    .out_ready (out_ready[2:0]),
    .err       (err3),
    .drop_cnt  (cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: index 0 models dut4, index 1 models dut3
  // ---------------------------------------------------------------------------
  int         nch  [2] = '{4, 3};
  int         cmax [2] = '{255, 3};
  bit         mv   [2][4];
  logic [7:0] md   [2][4];
  int         mcnt [2];
  bit         merr [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        mv[m][i] = 1'b0;
        md[m][i] = 8'h00;
      end
      mcnt[m] = 0;
      merr[m] = 1'b0;
    end
  endtask

  // Can instance m take the currently offered word?
  function automatic bit exp_ready(input int m);
    bit r;
    r = 1'b1;
    if (bcast) begin
      for (int i = 0; i < nch[m]; i++)
        if (mv[m][i] && !out_ready[i]) r = 1'b0;
    end else if (int'(sel) < nch[m]) begin
      r = !mv[m][sel] || out_ready[sel];
    end
    return r;
  endfunction

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_step();
    bit acc [2];
    for (int m = 0; m < 2; m++) acc[m] = in_valid && exp_ready(m);
    for (int m = 0; m < 2; m++) begin
      merr[m] = 1'b0;
      for (int i = 0; i < nch[m]; i++) begin
        if (acc[m] && (bcast || int'(sel) == i)) begin
          mv[m][i] = 1'b1;
          md[m][i] = data_in;
        end else if (out_ready[i]) begin
          mv[m][i] = 1'b0;
        end
      end
      if (acc[m] && !bcast && int'(sel) >= nch[m]) begin
        merr[m] = 1'b1;
        if (mcnt[m] < cmax[m]) mcnt[m]++;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] eb;
    logic [3:0]  ev;
    for (int m = 0; m < 2; m++) begin
      eb = '0;
      ev = '0;
      for (int i = 0; i < nch[m]; i++) begin
        eb[i*8 +: 8] = md[m][i];
        ev[i]        = mv[m][i];
      end
      if (m == 0) begin
        check("dut4.out",       out4, eb);
        check("dut4.out_valid", ov4,  ev);
        check("dut4.err",       err4, merr[0]);
        check("dut4.drop_cnt",  cnt4, mcnt[0]);
      end else begin
        check("dut3.out",       out3, eb[23:0]);
        check("dut3.out_valid", ov3,  ev[2:0]);
        check("dut3.err",       err3, merr[1]);
        check("dut3.drop_cnt",  cnt3, mcnt[1]);
      end
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] s,
                       input bit b, input logic [3:0] r);
    in_valid  = v;
    data_in   = d;
    sel       = s;
    bcast     = b;
    out_ready = r;
  endtask

  // One clock cycle. Check in_ready on the settled inputs, take the edge,
  // then check the registered outputs just after it.
  task automatic cycle();
    #1;
    check("dut4.in_ready", rdy4, exp_ready(0));
    check("dut3.in_ready", rdy3, exp_ready(1));
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  // Async reset asserted between edges. Outputs must clear without a clock.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 8'h00, 2'd0, 0, 4'h0);

    // T1: asynchronous reset with random inputs, checked before any clock edge
    #1;
    rst_n = 1'b0;
    drive($urandom_range(0, 1), 8'($urandom), 2'($urandom), $urandom_range(0, 1), 4'($urandom));
    #2;
    model_reset();
    compare_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 8'h00, 2'd0, 0, 4'h0);

    // T2: back-to-back unicast to every channel
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'hA1 + 8'(k), 2'(k), 0, 4'hF);
      cycle();
    end
    check("t2.out4", out4, 32'hA4A3A2A1);
    check("t2.ov4",  ov4,  4'b1000);

    // T3: backpressure on channel 2
    drive(1, 8'h55, 2'd2, 0, 4'b1011);
    cycle();
    drive(1, 8'h66, 2'd2, 0, 4'b1011);
    #1;
    check("t3.stall_ready", rdy4, 1'b0);
    cycle();
    check("t3.held", out4[23:16], 8'h55);
    drive(1, 8'h66, 2'd2, 0, 4'hF);
    cycle();
    check("t3.loaded", out4[23:16], 8'h66);

    // T4: broadcast blocked by a stalled channel, then released
    drive(1, 8'h3C, 2'd1, 1, 4'b1011);
    #1;
    check("t4.bcast_blocked", rdy4, 1'b0);
    cycle();
    check("t4.no_partial", out4, 32'h_A4_66_A2_A1);
    drive(1, 8'h3C, 2'd1, 1, 4'hF);
    cycle();
    check("t4.all4", out4, 32'h3C3C3C3C);
    check("t4.all3", out3, 24'h3C3C3C);
    check("t4.ov4",  ov4,  4'hF);

    // T5: bad sel on the 3-channel instance, then counter saturation
    mid_reset();
    drive(1, 8'h77, 2'd3, 0, 4'hF);
    cycle();
    check("t5.err",  err3, 1'b1);
    check("t5.cnt",  cnt3, 2'd1);
    check("t5.ov3",  ov3,  3'b000);
    drive(0, 8'h00, 2'd3, 0, 4'hF);
    cycle();
    check("t5.err_pulse", err3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'h77, 2'd3, 0, 4'hF);
      cycle();
    end
    check("t5.sat", cnt3, 2'd3);

    // T6: reset with all channels full, then normal delivery
    drive(1, 8'h99, 2'd0, 1, 4'hF);
    cycle();
    drive(0, 8'h00, 2'd0, 0, 4'h0);
    cycle();
    check("t6.full", ov4, 4'hF);
    mid_reset();
    drive(1, 8'h42, 2'd1, 0, 4'hF);
    cycle();
    check("t6.after_rst_data",  out4[15:8], 8'h42);
    check("t6.after_rst_valid", ov4, 4'b0010);

    // Randomized traffic against the model
    drive(0, 8'h00, 2'd0, 0, 4'h0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end
      drive($urandom_range(0, 3) != 0,
            8'($urandom),
            2'($urandom),
            $urandom_range(0, 7) == 0,
            {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
